// File: rtl/mips_pkg.sv
// Shared encodings for the Extended-MIPS multicycle control path: opcodes,
// ALUOp, datapath mux selects and the main control state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EXEC,
        S_ADDI_WB
    } ctrl_state_t;

endpackage

// File: rtl/mips_ctrl_wait_cnt.sv
// Memory wait-state counter: counts stalled cycles in a memory state and flags
// a timeout on the last allowed cycle (MEM_WAIT_LIMIT = 0 disables the timeout).
module mips_ctrl_wait_cnt #(
    parameter int MEM_WAIT_LIMIT = 0,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_mem_state_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam bit               LIMIT_EN = (MEM_WAIT_LIMIT > 0);
    localparam logic [CNT_W-1:0] LAST_CNT = LIMIT_EN ? CNT_W'(MEM_WAIT_LIMIT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A ready cycle on the limit wins over the timeout.
    assign timeout_o = LIMIT_EN && in_mem_state_i && !mem_ready_i && (cnt_q == LAST_CNT);

    // Any exit from a memory state (done or aborted) leaves the count at zero,
    // so every entry into FETCH/MEM_READ/MEM_WRITE starts from a clean count.
    always_comb begin
        cnt_d = '0;
        if (in_mem_state_i && !mem_ready_i && !timeout_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle main control FSM for the Extended-MIPS datapath with memory-ready
// handshake and optional timeout. Define MIPS_CTRL_ADDI_EN to decode ADDI.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_LIMIT = 0,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op1,
    output logic       alu_op0,
    output logic       bus_error,
    output logic       illegal_op
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        in_mem_state;
    logic        timeout;
    logic [1:0]  alu_op;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE);
    assign {alu_op1, alu_op0} = alu_op;

    mips_ctrl_wait_cnt #(
        .MEM_WAIT_LIMIT (MEM_WAIT_LIMIT),
        .CNT_W          (CNT_W)
    ) u_wait_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_mem_state_i (in_mem_state),
        .mem_ready_i    (mem_ready),
        .timeout_o      (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_ADD;
        bus_error     = timeout;
        illegal_op    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (timeout)        state_d = S_FETCH;
                else if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (timeout)        state_d = S_FETCH;
                else if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (timeout || mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = S_FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: per-instruction expected output
// sequences are built from the instruction-level rules and replayed cycle by cycle.
module tb_mips_multicycle_ctrl;

    localparam int LIMIT = 4;
    localparam logic [5:0] R_OP = 6'b000000, LW_OP = 6'b100011, SW_OP = 6'b101011;
    localparam logic [5:0] BEQ_OP = 6'b000100, J_OP = 6'b000010, ADDI_OP = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op1;
        logic       alu_op0;
        logic       bus_error;
        logic       illegal_op;
    } ov_t;

    typedef struct {
        logic       mr;
        logic [5:0] op;
        ov_t        exp;
        string      tag;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_op1, alu_op0;
    logic       bus_error, illegal_op;
    logic [1:0] pc_source, alu_src_b;
    ov_t        outs;

    int         vectors = 0;
    int         miscompares = 0;
    step_t      q[$];
    logic [5:0] cur_op;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1), .alu_op0(alu_op0),
        .bus_error(bus_error), .illegal_op(illegal_op)
    );

    assign outs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op1, alu_op0,
                   bus_error, illegal_op};

    task automatic push(input logic mr, input ov_t e, input string tag);
        step_t s;
        s.mr = mr; s.op = cur_op; s.exp = e; s.tag = tag;
        q.push_back(s);
    endtask

    // A memory access with `waits` not-ready cycles before ready; aborts after LIMIT stalls.
    task automatic mem_phase(input int waits, input ov_t base, input bit is_fetch,
                             input string tag, output bit aborted);
        aborted = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            ov_t  e;
            logic mr;
            e  = base;
            mr = (k >= waits);
            if (is_fetch) begin
                e.ir_write = mr;
                e.pc_write = mr;
            end
            if (!mr && LIMIT > 0 && k == LIMIT - 1) begin
                e.bus_error = 1'b1;
                push(1'b0, e, {tag, "_timeout"});
                aborted = 1'b1;
                return;
            end
            push(mr, e, tag);
            if (mr) return;
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
        ov_t e;
        bit  ab;
        bit  legal;
        cur_op = 6'($urandom);
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        mem_phase(fw, e, 1'b1, "fetch", ab);
        if (ab) return;
        cur_op = op;
        legal = (op == R_OP) || (op == LW_OP) || (op == SW_OP) || (op == BEQ_OP) || (op == J_OP);
`ifdef MIPS_CTRL_ADDI_EN
        legal = legal || (op == ADDI_OP);
`endif
        e = '0; e.alu_src_b = 2'b11;
        if (!legal) begin
            e.illegal_op = 1'b1;
            push(1'($urandom), e, "decode_illegal");
            return;
        end
        push(1'($urandom), e, "decode");
        e = '0;
        if (op == LW_OP || op == SW_OP) begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            push(1'($urandom), e, "mem_addr");
            e = '0; e.i_or_d = 1'b1;
            if (op == LW_OP) e.mem_read = 1'b1;
            else             e.mem_write = 1'b1;
            mem_phase(mw, e, 1'b0, (op == LW_OP) ? "mem_read" : "mem_write", ab);
            if (ab || op == SW_OP) return;
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            push(1'($urandom), e, "mem_wb");
        end else if (op == R_OP) begin
            e.alu_src_a = 1'b1; e.alu_op1 = 1'b1;
            push(1'($urandom), e, "execute");
            e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
            push(1'($urandom), e, "r_wb");
        end else if (op == BEQ_OP) begin
            e.alu_src_a = 1'b1; e.alu_op0 = 1'b1; e.pc_write_cond = 1'b1; e.pc_source = 2'b01;
            push(1'($urandom), e, "branch");
        end else if (op == J_OP) begin
            e.pc_write = 1'b1; e.pc_source = 2'b10;
            push(1'($urandom), e, "jump");
        end else begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            push(1'($urandom), e, "addi_exec");
            e = '0; e.reg_write = 1'b1;
            push(1'($urandom), e, "addi_wb");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (outs !== ov_t'(0)) begin
            miscompares++;
            $display("FAIL reset_held: got %b want %b", outs, ov_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== ov_t'(0)) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want %b", outs, ov_t'(0));
        end
    endtask

    task automatic test_directed();
        gen_instr(R_OP, 0, 0);
        gen_instr(LW_OP, 0, 3);
        gen_instr(SW_OP, 1, 0);
        gen_instr(BEQ_OP, 0, 0);
        gen_instr(J_OP, 2, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr; opcode = s.op;
            #1;
            vectors++;
            if (outs !== s.exp) begin
                miscompares++;
                $display("FAIL directed/%s: got %b want %b", s.tag, outs, s.exp);
            end
        end
    endtask

    task automatic test_timeout();
        gen_instr(R_OP, 4, 0);   // fetch abort
        gen_instr(R_OP, 3, 0);   // ready on the limit cycle wins
        gen_instr(LW_OP, 0, 4);  // MEM_READ abort, no writeback
        gen_instr(SW_OP, 0, 9);  // MEM_WRITE abort
        gen_instr(SW_OP, 0, 3);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr; opcode = s.op;
            #1;
            vectors++;
            if (outs !== s.exp) begin
                miscompares++;
                $display("FAIL timeout/%s: got %b want %b", s.tag, outs, s.exp);
            end
        end
    endtask

    task automatic test_addi_illegal();
        gen_instr(ADDI_OP, 0, 0);
        gen_instr(6'b111111, 0, 0);
        gen_instr(6'b100000, 1, 0);
        gen_instr(ADDI_OP, 0, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr; opcode = s.op;
            #1;
            vectors++;
            if (outs !== s.exp) begin
                miscompares++;
                $display("FAIL addi_illegal/%s: got %b want %b", s.tag, outs, s.exp);
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        ov_t e;
        cur_op = 6'($urandom);
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, e, "fetch");
        cur_op = LW_OP;
        e = '0; e.alu_src_b = 2'b11;
        push(1'b0, e, "decode");
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        push(1'b1, e, "mem_addr");
        e = '0; e.mem_read = 1'b1; e.i_or_d = 1'b1;
        push(1'b0, e, "mem_read");
        push(1'b0, e, "mem_read");
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr; opcode = s.op;
            #1;
            vectors++;
            if (outs !== s.exp) begin
                miscompares++;
                $display("FAIL mid_lw/%s: got %b want %b", s.tag, outs, s.exp);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== ov_t'(0)) begin
            miscompares++;
            $display("FAIL mid_lw/async_reset: got %b want %b", outs, ov_t'(0));
        end
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (outs !== ov_t'(0)) begin
            miscompares++;
            $display("FAIL mid_lw/idle_after_reset: got %b want %b", outs, ov_t'(0));
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP, 6'b000000};
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            gen_instr(op, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2));
        end
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr; opcode = s.op;
            #1;
            vectors++;
            if (outs !== s.exp) begin
                miscompares++;
                $display("FAIL random/%s: got %b want %b", s.tag, outs, s.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_addi_illegal();
        test_reset_mid_lw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
